ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle instruction sequencer for a small accumulator CPU.
// Walks FETCH1/FETCH2/DECODE and then one execute state for each instruction,
// producing one control vector per state. It also counts retired instructions
// and keeps a sticky flag for illegal opcodes.
// Optional feature: define CTRL_SINGLE_STEP_EN to add a `step` input.
// FETCH1 then waits for one rising edge of `step` before each instruction.
module ctrl_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic        z_flag,
    input  logic        mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [11:0] ctrlsig,
    output logic [3:0]  state_out,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    // control vector bit positions
    localparam logic [11:0] PC_INC  = 12'h001;
    localparam logic [11:0] PC_LOAD = 12'h002;
    localparam logic [11:0] AR_PC   = 12'h004;
    localparam logic [11:0] AR_IR   = 12'h008;
    localparam logic [11:0] MEM_RD  = 12'h010;
    localparam logic [11:0] MEM_WR  = 12'h020;
    localparam logic [11:0] IR_LOAD = 12'h040;
    localparam logic [11:0] AC_MEM  = 12'h080;
    localparam logic [11:0] AC_ALU  = 12'h100;
    localparam logic [11:0] ALU_SUB = 12'h200;
    localparam logic [11:0] DR_LOAD = 12'h400;
    localparam logic [11:0] BUSY    = 12'h800;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_DECODE = 4'd3,
        S_LOAD   = 4'd4,
        S_STORE  = 4'd5,
        S_ALU    = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    state_t      state, nxt;
    logic [3:0]  op_q;       // opcode captured in DECODE; ALU uses it to pick add or sub
    logic        cnt_en;
    logic        ill_dec;

`ifdef CTRL_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;
    assign step_rise = step & ~step_q;

    // remember the previous step level so that a held level counts as one step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // next-state logic and control decode
    // FETCH2 and LOAD also use mem_ready, so the completion strobes are issued
    // in the same cycle the memory finishes.
    always_comb begin
        nxt     = state;
        ctrlsig = '0;
        ill_dec = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) nxt = S_FETCH1;
            end
            S_FETCH1: begin
`ifdef CTRL_SINGLE_STEP_EN
                if (step_rise) begin
                    ctrlsig = AR_PC | BUSY;
                    nxt     = S_FETCH2;
                end else begin
                    ctrlsig = BUSY;
                end
`else
                ctrlsig = AR_PC | BUSY;
                nxt     = S_FETCH2;
`endif
            end
            S_FETCH2: begin
                ctrlsig = MEM_RD | BUSY;
                if (mem_ready) begin
                    ctrlsig = MEM_RD | BUSY | IR_LOAD | PC_INC;
                    nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrlsig = BUSY;
                case (opcode)
                    4'd0:       nxt = S_FETCH1;
                    4'd1:       nxt = S_LOAD;
                    4'd2:       nxt = S_STORE;
                    4'd3, 4'd4: nxt = S_ALU;
                    4'd5:       nxt = S_JUMP;
                    4'd6:       nxt = z_flag ? S_JUMP : S_FETCH1;
                    4'd15:      nxt = S_HALT;
                    default: begin
                        nxt     = S_FETCH1;
                        ill_dec = 1'b1;
                    end
                endcase
            end
            S_LOAD: begin
                ctrlsig = AR_IR | MEM_RD | BUSY;
                if (mem_ready) begin
                    ctrlsig = AR_IR | MEM_RD | BUSY | AC_MEM;
                    nxt     = S_FETCH1;
                end
            end
            S_STORE: begin
                ctrlsig = AR_IR | MEM_WR | BUSY;
                if (mem_ready) nxt = S_FETCH1;
            end
            S_ALU: begin
                ctrlsig = AC_ALU | DR_LOAD | BUSY | ((op_q == 4'd4) ? ALU_SUB : 12'h000);
                nxt     = S_FETCH1;
            end
            S_JUMP: begin
                ctrlsig = PC_LOAD | BUSY;
                nxt     = S_FETCH1;
            end
            S_HALT: begin
                nxt = S_HALT;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
        // An instruction retires when it returns to FETCH1 from any state after IDLE.
        cnt_en = (nxt == S_FETCH1) &&
                 (state inside {S_DECODE, S_LOAD, S_STORE, S_ALU, S_JUMP});
    end

    // latched opcode, sticky illegal flag, retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 4'd0;
            illegal     <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            if (state == S_DECODE) op_q <= opcode;
            if (ill_dec)           illegal <= 1'b1;
            if (cnt_en)            instr_count <= instr_count + 16'd1;
        end
    end

    assign state_out = state;
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer, checked against a scoreboard.
// The stimulus process queues the outputs it expects for each cycle.
// The monitor takes each expectation off the queue and compares it with the
// DUT outputs on the falling clock edge, or right away when an asynchronous
// check is triggered.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, z_flag, mem_ready;
    logic [3:0]  opcode;
    logic [11:0] ctrlsig;
    logic [3:0]  state_out;
    logic        halted, illegal;
    logic [15:0] instr_count;

    typedef struct {
        string       nm;
        logic [3:0]  st;
        logic [11:0] cs;
        logic        hl;
        logic        il;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    event chk_ev;

    ctrl_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .z_flag      (z_flag),
        .mem_ready   (mem_ready),
        .ctrlsig     (ctrlsig),
        .state_out   (state_out),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // monitor: compare one queued expectation per falling edge or immediate check
    always begin
        @(negedge clk or chk_ev);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (state_out !== e.st || ctrlsig !== e.cs || halted !== e.hl ||
                illegal !== e.il || instr_count !== e.cnt) begin
                errors++;
                $display("FAIL %s: got st=%0d cs=%h hl=%b il=%b cnt=%h, want st=%0d cs=%h hl=%b il=%b cnt=%h",
                         e.nm, state_out, ctrlsig, halted, illegal, instr_count,
                         e.st, e.cs, e.hl, e.il, e.cnt);
            end
        end
    end

    // queue the expectation for the current cycle, then step to just after the next rising edge
    task automatic cyc(input string nm, input logic [3:0] st, input logic [11:0] cs,
                       input logic hl, input logic il, input logic [15:0] cnt);
        exp_q.push_back('{nm, st, cs, hl, il, cnt});
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // queue an expectation and check it immediately, without waiting for a clock edge
    task automatic now(input string nm, input logic [3:0] st, input logic [11:0] cs,
                       input logic hl, input logic il, input logic [15:0] cnt);
        exp_q.push_back('{nm, st, cs, hl, il, cnt});
        ->chk_ev;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 4'd0; z_flag = 1'b0; mem_ready = 1'b1;
        #2;
        now("reset", 4'd0, 12'h000, 0, 0, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("idle_hold", 4'd0, 12'h000, 0, 0, 16'd0);
        start = 1'b1;
        cyc("idle_start", 4'd0, 12'h000, 0, 0, 16'd0);

        // NOP loop: 1,2,3,1 and one retired instruction
        cyc("nop_f1",  4'd1, 12'h804, 0, 0, 16'd0);
        cyc("nop_f2",  4'd2, 12'h851, 0, 0, 16'd0);
        cyc("nop_dec", 4'd3, 12'h800, 0, 0, 16'd0);
        start = 1'b0;
        cyc("nop_f1b", 4'd1, 12'h804, 0, 0, 16'd1);

        // LOAD with three wait cycles
        opcode = 4'd1;
        cyc("ld_f2",  4'd2, 12'h851, 0, 0, 16'd1);
        cyc("ld_dec", 4'd3, 12'h800, 0, 0, 16'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld_wait", 4'd4, 12'h818, 0, 0, 16'd1);
        mem_ready = 1'b1;
        cyc("ld_done", 4'd4, 12'h898, 0, 0, 16'd1);
        cyc("ld_f1",   4'd1, 12'h804, 0, 0, 16'd2);

        // STORE with one wait cycle
        opcode = 4'd2;
        cyc("st_f2",  4'd2, 12'h851, 0, 0, 16'd2);
        cyc("st_dec", 4'd3, 12'h800, 0, 0, 16'd2);
        mem_ready = 1'b0;
        cyc("st_wait", 4'd5, 12'h828, 0, 0, 16'd2);
        mem_ready = 1'b1;
        cyc("st_done", 4'd5, 12'h828, 0, 0, 16'd2);
        cyc("st_f1",   4'd1, 12'h804, 0, 0, 16'd3);

        // SUB; the opcode changes during ALU so the latched value must be used
        opcode = 4'd4;
        cyc("sub_f2",  4'd2, 12'h851, 0, 0, 16'd3);
        cyc("sub_dec", 4'd3, 12'h800, 0, 0, 16'd3);
        opcode = 4'd3;
        cyc("sub_alu", 4'd6, 12'hF00, 0, 0, 16'd3);
        cyc("sub_f1",  4'd1, 12'h804, 0, 0, 16'd4);

        // ADD
        cyc("add_f2",  4'd2, 12'h851, 0, 0, 16'd4);
        cyc("add_dec", 4'd3, 12'h800, 0, 0, 16'd4);
        opcode = 4'd4;
        cyc("add_alu", 4'd6, 12'hD00, 0, 0, 16'd4);
        cyc("add_f1",  4'd1, 12'h804, 0, 0, 16'd5);

        // JMPZ not taken, then taken
        opcode = 4'd6; z_flag = 1'b0;
        cyc("jz0_f2",  4'd2, 12'h851, 0, 0, 16'd5);
        cyc("jz0_dec", 4'd3, 12'h800, 0, 0, 16'd5);
        cyc("jz0_f1",  4'd1, 12'h804, 0, 0, 16'd6);
        z_flag = 1'b1;
        cyc("jz1_f2",  4'd2, 12'h851, 0, 0, 16'd6);
        cyc("jz1_dec", 4'd3, 12'h800, 0, 0, 16'd6);
        z_flag = 1'b0;
        cyc("jz1_jmp", 4'd7, 12'h802, 0, 0, 16'd6);
        cyc("jz1_f1",  4'd1, 12'h804, 0, 0, 16'd7);

        // illegal opcode; the flag stays set through a later NOP
        opcode = 4'd9;
        cyc("ill_f2",  4'd2, 12'h851, 0, 0, 16'd7);
        cyc("ill_dec", 4'd3, 12'h800, 0, 0, 16'd7);
        opcode = 4'd0;
        cyc("ill_f1",  4'd1, 12'h804, 0, 1, 16'd8);
        cyc("ill_nf2", 4'd2, 12'h851, 0, 1, 16'd8);
        cyc("ill_ndc", 4'd3, 12'h800, 0, 1, 16'd8);
        cyc("ill_nf1", 4'd1, 12'h804, 0, 1, 16'd9);

        // counter wrap: preload 0xFFFF while FETCH2 waits, then retire a NOP
        mem_ready = 1'b0;
        cyc("wr_wait", 4'd2, 12'h810, 0, 1, 16'd9);
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        mem_ready = 1'b1;
        cyc("wr_f2",  4'd2, 12'h851, 0, 1, 16'hFFFF);
        cyc("wr_dec", 4'd3, 12'h800, 0, 1, 16'hFFFF);
        cyc("wr_f1",  4'd1, 12'h804, 0, 1, 16'h0000);

        // asynchronous reset pulse while FETCH2 is waiting on memory
        mem_ready = 1'b0;
        cyc("ar_wait", 4'd2, 12'h810, 0, 1, 16'h0000);
        #1 rst_n = 1'b0;
        #1 now("ar_async", 4'd0, 12'h000, 0, 0, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        cyc("ar_idle", 4'd0, 12'h000, 0, 0, 16'h0000);

        // HALT; toggling start afterwards has no effect
        start = 1'b1; opcode = 4'd15;
        cyc("h_idle", 4'd0, 12'h000, 0, 0, 16'd0);
        cyc("h_f1",   4'd1, 12'h804, 0, 0, 16'd0);
        cyc("h_f2",   4'd2, 12'h851, 0, 0, 16'd0);
        cyc("h_dec",  4'd3, 12'h800, 0, 0, 16'd0);
        cyc("h_halt", 4'd8, 12'h000, 1, 0, 16'd0);
        start = 1'b0;
        cyc("h_st0",  4'd8, 12'h000, 1, 0, 16'd0);
        start = 1'b1;
        cyc("h_st1",  4'd8, 12'h000, 1, 0, 16'd0);

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
